// File: rtl/sample_pipe_pkg.sv
// Shared types and constants for the elastic sample pipeline.
package sample_pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} stage_state_e;

    localparam int STAT_W = 32;

    function automatic int samp_w(input int data_size, input int data_per_sample);
        return data_size * data_per_sample;
    endfunction
endpackage

// File: rtl/sample_skid_stage.sv
// One 2-entry skid-buffer stage; ready depends only on the registered state.
module sample_skid_stage
    import sample_pipe_pkg::*;
#(
    parameter int SAMP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [SAMP_W-1:0] up_sample,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [SAMP_W-1:0] dn_sample,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [1:0]        count
);
    stage_state_e      state, state_nxt;
    logic [SAMP_W-1:0] head, skid;
    logic              acc, emit;

    always_ff @(posedge clk) begin
        if (rst || clr) state <= EMPTY;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (acc) state_nxt = ONE;
            ONE: begin
                if (acc && !emit)      state_nxt = TWO;
                else if (!acc && emit) state_nxt = EMPTY;
            end
            TWO:     if (emit) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // The state encoding doubles as the entry count.
    always_comb begin
        up_ready  = en && (state != TWO);
        dn_valid  = en && (state != EMPTY);
        dn_sample = head;
        count     = state;
    end

    assign acc  = up_valid && up_ready;
    assign emit = dn_valid && dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else if (!clr) begin
            case (state)
                EMPTY: if (acc) head <= up_sample;
                ONE: begin
                    if (emit) begin
                        if (acc) head <= up_sample;
                    end else if (acc) begin
                        skid <= up_sample;
                    end
                end
                TWO:     if (emit) head <= skid;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/sample_elastic_pipeline.sv
// DEPTH-stage elastic sample pipeline with enable, flush and occupancy.
// Optional counters xfer_count/stall_count when SAMPLE_PIPE_STATS_EN is defined.
module sample_elastic_pipeline
    import sample_pipe_pkg::*;
#(
    parameter int DATA_SIZE       = 4,
    parameter int DATA_PER_SAMPLE = 4,
    parameter int DEPTH           = 5,
    parameter int SAMP_W          = samp_w(DATA_SIZE, DATA_PER_SAMPLE),
    parameter int CNT_W           = $clog2(2 * DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SAMP_W-1:0] in_sample,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SAMP_W-1:0] out_sample,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              enable,
    input  logic              flush,
    output logic [CNT_W-1:0]  occupancy
`ifdef SAMPLE_PIPE_STATS_EN
   ,output logic [STAT_W-1:0] xfer_count,
    output logic [STAT_W-1:0] stall_count
`endif
);
    logic                    run;
    logic [DEPTH:0][SAMP_W-1:0] smp;
    logic [DEPTH:0]          vld, rdy;
    logic [DEPTH-1:0][1:0]   cnt;

    assign run    = enable && !flush;
    assign smp[0] = in_sample;
    assign vld[0] = in_valid;
    assign rdy[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        sample_skid_stage #(.SAMP_W(SAMP_W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .clr       (flush),
            .en        (run),
            .up_sample (smp[i]),
            .up_valid  (vld[i]),
            .up_ready  (rdy[i]),
            .dn_sample (smp[i+1]),
            .dn_valid  (vld[i+1]),
            .dn_ready  (rdy[i+1]),
            .count     (cnt[i])
        );
    end

    assign in_ready   = rdy[0] && !rst;
    assign out_valid  = vld[DEPTH] && !rst;
    assign out_sample = smp[DEPTH];

    // Stage counts are registers, so this sum moves on the transfer edge.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + CNT_W'(cnt[i]);
    end

`ifdef SAMPLE_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count  <= '0;
            stall_count <= '0;
        end else if (enable) begin
            if (out_valid && out_ready && (xfer_count != '1))
                xfer_count <= xfer_count + STAT_W'(1);
            if (out_valid && !out_ready && (stall_count != '1))
                stall_count <= stall_count + STAT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_sample_elastic_pipeline.sv
// Randomised bench for sample_elastic_pipeline against a count/queue model.
// Stats checks are compiled in when SAMPLE_PIPE_STATS_EN is defined.
module tb_sample_elastic_pipeline;
    localparam int D  = 5;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] in_sample = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SW-1:0] out_sample;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          enable = 1'b1;
    logic          flush = 1'b0;
    logic [3:0]    occupancy;
`ifdef SAMPLE_PIPE_STATS_EN
    logic [31:0]   xfer_count, stall_count;
`endif

    sample_elastic_pipeline #(.DATA_SIZE(4), .DATA_PER_SAMPLE(4), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .enable     (enable),
        .flush      (flush),
        .occupancy  (occupancy)
`ifdef SAMPLE_PIPE_STATS_EN
       ,.xfer_count (xfer_count),
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    // Model: entries per stage plus one FIFO of all held samples.
    int            cnt[D];
    logic [SW-1:0] q[$];
    logic [31:0]   m_xfer, m_stall;

    int n_vec = 0, n_err = 0, cur = 0;
    bit chk_on = 1'b0;
    bit hs_in, hs_out;
    logic          s_ir, s_ov;
    logic [3:0]    s_occ;
    logic [SW-1:0] s_out;
    logic [31:0]   s_xfer, s_stall;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cur, act, exp);
        end
    endtask

    task automatic cyc(input bit iv, input logic [SW-1:0] d, input bit ordy,
                       input bit en, input bit fl, input bit rs);
        bit g, e_ir, e_ov, mv[D+1];
        int occ;
        @(negedge clk);
        in_valid = iv; in_sample = d; out_ready = ordy; enable = en; flush = fl; rst = rs;
        #1;
        g    = en && !fl && !rs;
        e_ir = g && (cnt[0] < 2);
        e_ov = g && (cnt[D-1] > 0);
        occ  = 0;
        foreach (cnt[i]) occ += cnt[i];
        s_ir = in_ready; s_ov = out_valid; s_occ = occupancy; s_out = out_sample;
`ifdef SAMPLE_PIPE_STATS_EN
        s_xfer = xfer_count; s_stall = stall_count;
`else
        s_xfer = m_xfer; s_stall = m_stall;
`endif
        if (chk_on) begin
            chk("in_ready", 32'(s_ir), 32'(e_ir));
            chk("out_valid", 32'(s_ov), 32'(e_ov));
            chk("occupancy", 32'(s_occ), 32'(occ));
            if (e_ov) chk("out_sample", 32'(s_out), 32'(q[0]));
`ifdef SAMPLE_PIPE_STATS_EN
            chk("xfer_count", s_xfer, m_xfer);
            chk("stall_count", s_stall, m_stall);
`endif
        end
        hs_in  = iv && e_ir;
        hs_out = e_ov && ordy;
        if (rs) begin
            foreach (cnt[i]) cnt[i] = 0;
            q.delete();
            m_xfer = 0; m_stall = 0;
        end else if (fl) begin
            foreach (cnt[i]) cnt[i] = 0;
            q.delete();
        end else if (en) begin
            mv[0] = hs_in;
            for (int i = 1; i < D; i++) mv[i] = (cnt[i-1] > 0) && (cnt[i] < 2);
            mv[D] = hs_out;
            for (int i = 0; i < D; i++) cnt[i] += int'(mv[i]) - int'(mv[i+1]);
            if (hs_in) q.push_back(d);
            if (hs_out) void'(q.pop_front());
            if (hs_out && m_xfer != 32'hFFFF_FFFF) m_xfer++;
            if (e_ov && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
        end
        cur++;
    endtask

    task automatic do_reset();
        cyc(1'b1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [SW-1:0] exp4[4];
        logic [SW-1:0] got[$];
        int first_acc, first_out, last_out, acc, outs, stalls;
        logic [3:0] occ0;
        exp4[0] = 16'h0F3A; exp4[1] = 16'hCC81; exp4[2] = 16'h3A58; exp4[3] = 16'h9696;
        foreach (cnt[i]) cnt[i] = 0;
        m_xfer = 0; m_stall = 0;

        // Reset: first edge unchecked (registers still unknown), then two checked cycles.
        do_reset();
        chk_on = 1'b1;
        do_reset(); chk("rst in_ready", 32'(s_ir), 32'd0); chk("rst out_valid", 32'(s_ov), 32'd0);
        do_reset(); chk("rst occupancy", 32'(s_occ), 32'd0); chk("rst out_sample", 32'(s_out), 32'd0);
        chk("rst xfer", s_xfer, 32'd0); chk("rst stall", s_stall, 32'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("post-rst in_ready", 32'(s_ir), 32'd1);

        // Stream: four samples back to back, out_ready high.
        first_acc = -1; first_out = -1; last_out = -1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, exp4[i], 1'b1, 1'b1, 1'b0, 1'b0);
            if (hs_in && first_acc < 0) first_acc = cur - 1;
        end
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (hs_out) begin
                got.push_back(s_out);
                if (first_out < 0) first_out = cur - 1;
                last_out = cur - 1;
            end
        end
        chk("stream count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("stream order", 32'(got[i]), 32'(exp4[i]));
        chk("stream latency", 32'(first_out - first_acc), 32'd5);
        chk("stream consecutive", 32'(last_out - first_out), 32'd3);

        // Backpressure: fill with out_ready low, then drain.
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0, 1'b0);
            if (hs_in) acc++;
        end
        chk("full accepts", 32'(acc), 32'd10);
        chk("full occupancy", 32'(s_occ), 32'd10);
        chk("full in_ready", 32'(s_ir), 32'd0);
        outs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (hs_out) outs++;
        end
        chk("drain outputs", 32'(outs), 32'd10);
        chk("drain occupancy", 32'(s_occ), 32'd0);

        // Flush with six samples held.
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'hF000 | 16'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("preflush occupancy", 32'(s_occ), 32'd6);
        chk("flush in_ready", 32'(s_ir), 32'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("postflush occupancy", 32'(s_occ), 32'd0);
        chk("postflush out_valid", 32'(s_ov), 32'd0);
        outs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (s_ov) outs++;
        end
        chk("flushed never out", 32'(outs), 32'd0);

        // Enable dropped for three cycles mid-stream.
        for (int i = 0; i < 7; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0); occ0 = s_occ;
        chk("disabled hs", 32'({s_ir, s_ov}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("disabled occ", 32'(s_occ), 32'(occ0));
            chk("disabled hs", 32'({s_ir, s_ov}), 32'd0);
        end
        cyc(1'b1, 16'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reenable occ", 32'(s_occ), 32'(occ0));
        chk("reenable hs", 32'({s_ir, s_ov}), 32'd3);
        for (int i = 0; i < 12; i++) cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random traffic including rare flush and reset.
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
                $urandom_range(0, 19) < 17, $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);

`ifdef SAMPLE_PIPE_STATS_EN
        // Stats: 20 transfers with exactly 7 stall cycles, then a flush.
        do_reset();
        acc = 0; outs = 0; stalls = 0;
        for (int i = 0; i < 300 && outs < 20; i++) begin
            bit ordy;
            ordy = !((cnt[D-1] > 0) && stalls < 7);
            if (cnt[D-1] > 0 && !ordy) stalls++;
            cyc(acc < 20, 16'($urandom), ordy, 1'b1, 1'b0, 1'b0);
            if (hs_in) acc++;
            if (hs_out) outs++;
        end
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stats xfer", s_xfer, 32'd20);
        chk("stats stall", s_stall, 32'd7);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("stats xfer after flush", s_xfer, 32'd20);
        chk("stats stall after flush", s_stall, 32'd7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
